// File: rtl/id_scoreboard.sv
// Register scoreboard for in-order issue: tracks pending destination registers with a
// per-register latency countdown, raising decode stalls on RAW/WAW hazards and bypass selects.
module id_scoreboard #(
    parameter int NREGS   = 32,
    parameter int RADDR_W = 5,
    parameter int LAT_W   = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [RADDR_W-1:0] rs1_raddr_i,
    input  logic [RADDR_W-1:0] rs2_raddr_i,
    input  logic               rs1_re_i,
    input  logic               rs2_re_i,
    input  logic               issue_valid_i,
    input  logic               issue_we_i,
    input  logic [RADDR_W-1:0] issue_rd_i,
    input  logic [LAT_W-1:0]   issue_lat_i,
    input  logic               wb_we_i,
    input  logic [RADDR_W-1:0] wb_rd_i,
    input  logic               flush_i,
    output logic               stallreq_o,
    output logic               rs1_fwd_o,
    output logic               rs2_fwd_o,
    output logic               issue_fire_o,
    output logic [RADDR_W:0]   pending_cnt_o
);

    logic [NREGS-1:0] r_pend;
    logic [LAT_W-1:0] r_cnt [NREGS];
    logic [RADDR_W:0] r_pcnt;

    logic             w_rs1_live;
    logic             w_rs2_live;
    logic             w_rd_live;
    logic             w_rs1_busy;
    logic             w_rs2_busy;
    logic             w_rd_busy;
    logic             w_stall;
    logic             w_fire;
    logic [NREGS-1:0] w_pend_nxt;
    logic [LAT_W-1:0] w_cnt_nxt [NREGS];
    logic [RADDR_W:0] w_pcnt_nxt;

    // A register is "live" when it is pending; "busy" when its result is not yet forwardable.
    always_comb begin
        w_rs1_live = rs1_re_i && (rs1_raddr_i != '0) && r_pend[rs1_raddr_i];
        w_rs2_live = rs2_re_i && (rs2_raddr_i != '0) && r_pend[rs2_raddr_i];
        w_rd_live  = issue_we_i && (issue_rd_i != '0) && r_pend[issue_rd_i];
        w_rs1_busy = w_rs1_live && (r_cnt[rs1_raddr_i] != '0);
        w_rs2_busy = w_rs2_live && (r_cnt[rs2_raddr_i] != '0);
        w_rd_busy  = w_rd_live  && (r_cnt[issue_rd_i]  != '0);
        w_stall    = !rst_i && issue_valid_i && (w_rs1_busy || w_rs2_busy || w_rd_busy);
        w_fire     = !rst_i && issue_valid_i && !w_stall && !flush_i;
    end

    assign stallreq_o    = w_stall;
    assign issue_fire_o  = w_fire;
    assign rs1_fwd_o     = !rst_i && w_rs1_live && (r_cnt[rs1_raddr_i] == '0);
    assign rs2_fwd_o     = !rst_i && w_rs2_live && (r_cnt[rs2_raddr_i] == '0);
    assign pending_cnt_o = r_pcnt;

    // Priority per register: flush, then a new issue, then writeback, then countdown.
    always_comb begin
        w_pend_nxt = '0;
        w_pcnt_nxt = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            w_pend_nxt[i] = r_pend[i];
            w_cnt_nxt[i]  = r_cnt[i];
            if (i == 0) begin
                w_pend_nxt[i] = 1'b0;
                w_cnt_nxt[i]  = '0;
            end else if (flush_i) begin
                w_pend_nxt[i] = 1'b0;
                w_cnt_nxt[i]  = '0;
            end else if (w_fire && issue_we_i && (issue_rd_i == RADDR_W'(i))) begin
                w_pend_nxt[i] = 1'b1;
                w_cnt_nxt[i]  = issue_lat_i;
            end else if (wb_we_i && (wb_rd_i == RADDR_W'(i))) begin
                w_pend_nxt[i] = 1'b0;
                w_cnt_nxt[i]  = '0;
            end else if (r_cnt[i] != '0) begin
                w_cnt_nxt[i]  = r_cnt[i] - LAT_W'(1);
            end
            w_pcnt_nxt = w_pcnt_nxt + (RADDR_W+1)'(w_pend_nxt[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend <= '0;
            r_pcnt <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_pend <= w_pend_nxt;
            r_pcnt <= w_pcnt_nxt;
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: directed vector table for the corner cases, then
// random traffic checked against a ready-time reference model.
module tb_id_scoreboard;

    localparam int NREGS   = 32;
    localparam int RADDR_W = 5;
    localparam int LAT_W   = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [RADDR_W-1:0] a1, a2, rd, wbrd;
    logic               re1, re2, valid, we, wbwe, flush;
    logic [LAT_W-1:0]   lat;
    logic               stall, fwd1, fwd2, fire;
    logic [RADDR_W:0]   pcnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_scoreboard #(.NREGS(NREGS), .RADDR_W(RADDR_W), .LAT_W(LAT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .rs1_raddr_i(a1), .rs2_raddr_i(a2), .rs1_re_i(re1), .rs2_re_i(re2),
        .issue_valid_i(valid), .issue_we_i(we), .issue_rd_i(rd), .issue_lat_i(lat),
        .wb_we_i(wbwe), .wb_rd_i(wbrd), .flush_i(flush),
        .stallreq_o(stall), .rs1_fwd_o(fwd1), .rs2_fwd_o(fwd2),
        .issue_fire_o(fire), .pending_cnt_o(pcnt)
    );

    // Reference model: a pending register becomes forwardable at absolute cycle m_ready.
    bit m_pend [NREGS];
    int m_ready [NREGS];
    int cyc = 0;

    typedef struct {
        bit rst, valid, we, re1, re2, wbwe, flush;
        int rd, lat, a1, a2, wbrd;
        bit e_stall, e_fwd1, e_fwd2, e_fire;
        int e_pcnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit v, bit w, int d, int l, bit e1, int s1, bit e2, int s2,
                                bit bw, int bd, bit f, bit xs, bit x1, bit x2, bit xf, int xp);
        vec_t t;
        t.rst = r; t.valid = v; t.we = w; t.rd = d; t.lat = l;
        t.re1 = e1; t.a1 = s1; t.re2 = e2; t.a2 = s2; t.wbwe = bw; t.wbrd = bd; t.flush = f;
        t.e_stall = xs; t.e_fwd1 = x1; t.e_fwd2 = x2; t.e_fire = xf; t.e_pcnt = xp;
        return t;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_busy(int r);
        return r != 0 && m_pend[r] && m_ready[r] > cyc;
    endfunction

    function automatic bit m_fwdable(int r);
        return r != 0 && m_pend[r] && m_ready[r] <= cyc;
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NREGS; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    function automatic bit m_stall();
        return !rst && valid && ((re1 && m_busy(int'(a1))) || (re2 && m_busy(int'(a2))) ||
                                 (we && m_busy(int'(rd))));
    endfunction

    // Checks outputs (against the table when use_tab, else the model), then advances one clock.
    task automatic step(bit use_tab, vec_t t);
        bit mf;
        #2;
        mf = !rst && valid && !m_stall() && !flush;
        if (use_tab) begin
            chk("tab_stall", int'(stall), int'(t.e_stall));
            chk("tab_fwd1",  int'(fwd1),  int'(t.e_fwd1));
            chk("tab_fwd2",  int'(fwd2),  int'(t.e_fwd2));
            chk("tab_fire",  int'(fire),  int'(t.e_fire));
            chk("tab_pcnt",  int'(pcnt),  t.e_pcnt);
        end else begin
            chk("rnd_stall", int'(stall), int'(m_stall()));
            chk("rnd_fwd1",  int'(fwd1),  int'(!rst && re1 && m_fwdable(int'(a1))));
            chk("rnd_fwd2",  int'(fwd2),  int'(!rst && re2 && m_fwdable(int'(a2))));
            chk("rnd_fire",  int'(fire),  int'(mf));
            chk("rnd_pcnt",  int'(pcnt),  m_count());
        end
        @(posedge clk);
        #1;
        if (rst || flush) begin
            for (int i = 0; i < NREGS; i++) m_pend[i] = 0;
        end else begin
            if (wbwe) m_pend[wbrd] = 0;
            if (mf && we && rd != 0) begin
                m_pend[rd]  = 1;
                m_ready[rd] = cyc + 1 + int'(lat);
            end
        end
        cyc++;
    endtask

    task automatic drive(vec_t t);
        rst = t.rst; valid = t.valid; we = t.we; rd = RADDR_W'(t.rd); lat = LAT_W'(t.lat);
        re1 = t.re1; a1 = RADDR_W'(t.a1); re2 = t.re2; a2 = RADDR_W'(t.a2);
        wbwe = t.wbwe; wbrd = RADDR_W'(t.wbrd); flush = t.flush;
    endtask

    initial begin
        vec_t idle;
        idle = mk(0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0);
        //          rst v we rd lat re1 a1 re2 a2 wb wbrd fl  stall f1 f2 fire pcnt
        vecs.push_back(mk(0,1,1, 5,2, 0,0, 0,0, 0,0, 0,  0,0,0,1,0)); // rd5 lat2
        vecs.push_back(mk(0,1,0, 0,0, 1,5, 0,0, 0,0, 0,  1,0,0,0,1));
        vecs.push_back(mk(0,1,0, 0,0, 1,5, 0,0, 0,0, 0,  1,0,0,0,1));
        vecs.push_back(mk(0,1,0, 0,0, 1,5, 0,0, 0,0, 0,  0,1,0,1,1));
        vecs.push_back(mk(0,0,0, 0,0, 0,0, 0,0, 1,5, 0,  0,0,0,0,1));
        vecs.push_back(mk(0,1,1, 7,0, 0,0, 0,0, 0,0, 0,  0,0,0,1,0)); // rd7 lat0
        vecs.push_back(mk(0,0,0, 0,0, 0,0, 1,7, 1,7, 0,  0,0,1,0,1));
        vecs.push_back(mk(0,0,0, 0,0, 0,0, 1,7, 0,0, 0,  0,0,0,0,0));
        vecs.push_back(mk(0,1,1, 0,3, 0,0, 0,0, 0,0, 0,  0,0,0,1,0)); // rd0 ignored
        vecs.push_back(mk(0,1,0, 0,0, 1,0, 1,0, 0,0, 0,  0,0,0,1,0));
        vecs.push_back(mk(0,1,1, 3,2, 0,0, 0,0, 0,0, 0,  0,0,0,1,0)); // WAW on rd3
        vecs.push_back(mk(0,1,1, 3,1, 0,0, 0,0, 0,0, 0,  1,0,0,0,1));
        vecs.push_back(mk(0,1,1, 3,1, 0,0, 0,0, 0,0, 0,  1,0,0,0,1));
        vecs.push_back(mk(0,1,1, 3,1, 0,0, 0,0, 0,0, 0,  0,0,0,1,1));
        vecs.push_back(mk(0,1,1, 4,3, 0,0, 0,0, 0,0, 0,  0,0,0,1,1));
        vecs.push_back(mk(0,1,1, 6,3, 0,0, 0,0, 0,0, 0,  0,0,0,1,2));
        vecs.push_back(mk(0,1,1, 8,1, 0,0, 0,0, 1,3, 1,  0,0,0,0,3)); // flush
        vecs.push_back(mk(0,1,1, 3,0, 1,4, 1,6, 0,0, 0,  0,0,0,1,0));
        vecs.push_back(mk(0,1,1, 9,1, 0,0, 0,0, 1,9, 0,  0,0,0,1,1)); // issue beats wb
        vecs.push_back(mk(0,1,0, 0,0, 1,9, 0,0, 0,0, 0,  1,0,0,0,2));
        vecs.push_back(mk(0,1,0, 0,0, 1,9, 0,0, 0,0, 0,  0,1,0,1,2));
        vecs.push_back(mk(0,1,1,10,7, 0,0, 0,0, 0,0, 0,  0,0,0,1,2)); // reset mid-countdown
        vecs.push_back(mk(1,1,1,11,2, 1,10,1,9, 0,0, 0,  0,0,0,0,3));
        vecs.push_back(mk(0,1,1,10,1, 1,10,0,0, 0,0, 0,  0,0,0,1,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,0, 0,0, 1,12,0,  0,0,0,0,1)); // wb to idle reg
        vecs.push_back(mk(0,0,0, 0,0, 0,0, 0,0, 0,0, 0,  0,0,0,0,1));

        drive(idle);
        rst = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < NREGS; i++) begin
            m_pend[i] = 0;
            m_ready[i] = 0;
        end
        drive(idle);
        rst = 1;
        step(0, idle);

        foreach (vecs[k]) begin
            drive(vecs[k]);
            step(1, vecs[k]);
        end

        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 99) < 3);
            valid = ($urandom_range(0, 3) != 0);
            we    = ($urandom_range(0, 3) != 0);
            rd    = RADDR_W'($urandom_range(0, 7));
            lat   = LAT_W'($urandom_range(0, 7));
            re1   = $urandom_range(0, 1) == 1;
            re2   = $urandom_range(0, 1) == 1;
            a1    = RADDR_W'($urandom_range(0, 7));
            a2    = RADDR_W'($urandom_range(0, 7));
            wbwe  = ($urandom_range(0, 3) == 0);
            wbrd  = RADDR_W'($urandom_range(0, 7));
            step(0, idle);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_scoreboard.md
ID_SCOREBOARD -- requirements
Module: id_scoreboard

Interface
REQ-001 Parameter NREGS, default 32: number of architectural integer registers tracked; power of two, 2..64.
REQ-002 Parameter RADDR_W, default 5: register address width; equals log2(NREGS).
REQ-003 Parameter LAT_W, default 3: width of the per-register latency countdown; max issue latency is 2^LAT_W-1.
REQ-004 Clock and reset SHALL be one clock, clk_i; reset rst_i is synchronous and active-high.
REQ-005 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 rs1_raddr_i / rs2_raddr_i  in  RADDR_W each  source registers of instruction in decode.
REQ-008 rs1_re_i / rs2_re_i  in  1 each  source read enables.
REQ-009 issue_valid_i  in  1  decode instruction is valid and attempting to issue.
REQ-010 issue_we_i  in  1  instruction writes a destination register.
REQ-011 issue_rd_i  in  RADDR_W  destination register.
REQ-012 issue_lat_i  in  LAT_W  cycles after issue until result is forwardable; 0 = single-cycle ALU op.
REQ-013 wb_we_i / wb_rd_i  in  1 / RADDR_W  register-file writeback retiring a pending register.
REQ-014 flush_i  in  1  pipeline flush (branch/trap); discards all pending entries.
REQ-015 stallreq_o  out  1  to ctrl; decode must hold.
REQ-016 rs1_fwd_o / rs2_fwd_o  out  1 each  operand must be taken from bypass, not regfile.
REQ-017 issue_fire_o  out  1  issue accepted this cycle.
REQ-018 pending_cnt_o  out  RADDR_W+1  number of registers currently pending.

Function
REQ-019 State per register r: pend[r] (1 bit), cnt[r] (LAT_W bits); register 0 SHALL never become pending.
REQ-020 Source hazard: rsN_re_i && rsN_raddr_i!=0 && pend[rsN] && cnt[rsN]!=0.
REQ-021 WAW hazard: issue_we_i && issue_rd_i!=0 && pend[issue_rd_i] && cnt[issue_rd_i]!=0.
REQ-022 stallreq_o = issue_valid_i && (rs1 hazard || rs2 hazard || WAW hazard); combinational from state and inputs, no cycle delay.
REQ-023 rsN_fwd_o = rsN_re_i && rsN_raddr_i!=0 && pend[rsN] && cnt[rsN]==0; independent of issue_valid_i.
REQ-024 issue_fire_o = issue_valid_i && !stallreq_o && !flush_i.
REQ-025 On issue_fire_o with issue_we_i && issue_rd_i!=0: next cycle pend[rd]=1, cnt[rd]=issue_lat_i.
REQ-026 Each cycle every pending register with cnt!=0 not being re-issued SHALL decrement cnt by 1; saturate at 0.
REQ-027 wb_we_i with wb_rd_i!=0 SHALL clear pend[wb_rd_i] and cnt[wb_rd_i] next cycle.
REQ-028 Simultaneous issue and writeback to same rd: issue wins (pend=1, cnt=issue_lat_i).
REQ-029 flush_i SHALL clear all pend and cnt next cycle and suppress issue that cycle; flush overrides issue and writeback.
REQ-030 Writeback to a non-pending register SHALL be ignored without error.
REQ-031 pending_cnt_o SHALL be the registered population count of pend, valid the cycle after each update.
REQ-032 Issue latency: registered state; a consumer in the cycle after issue sees the new entry.

Reset
REQ-033 On rst_i high at a clock edge: all pend=0, all cnt=0, pending_cnt_o=0; reset overrides flush, issue, writeback.
REQ-034 While rst_i high, stallreq_o=0, rs1_fwd_o=rs2_fwd_o=0, issue_fire_o=0.
REQ-035 Reset asserted mid-countdown SHALL discard all entries; first cycle after reset shows no hazards.

Verification
REQ-036 Issue rd=5 lat=2 at T; at T+1 decode rs1=5 -> stallreq_o=1; T+2 stall=1; T+3 stall=0, rs1_fwd_o=1.
REQ-037 Issue rd=7 lat=0 at T; T+1 rs2=7 -> stallreq_o=0, rs2_fwd_o=1; wb rd=7 at T+1 -> T+2 rs2_fwd_o=0, pending_cnt_o=0.
REQ-038 Issue rd=0 lat=3 -> pend unchanged, pending_cnt_o stays 0, later rs1=0 never stalls or forwards.
REQ-039 rd=3 pending cnt=2, issue again rd=3 -> WAW stallreq_o=1, issue_fire_o=0 until cnt=0.
REQ-040 Three registers pending (pending_cnt_o=3), flush_i pulse with issue_valid_i=1 -> issue_fire_o=0, next cycle pending_cnt_o=0, no stalls.
REQ-041 Same-cycle issue rd=9 lat=1 and wb rd=9 -> next cycle pend[9]=1, cnt=1, rs1=9 stalls one cycle.
